// File: rtl/slant_link_pkg.sv
// Shared slant link definitions: framing patterns, symbol encodings and lane states.
// Imported by both the lane receiver and the transmitter.
package slant_link_pkg;

  localparam logic [23:0] FRAME1    = 24'haab155;
  localparam logic [23:0] FRAME0    = 24'haa8d55;
  localparam logic [15:0] HSYNC     = 16'ha355;
  localparam logic [7:0]  SYM_ONE   = 8'hff;
  localparam logic [7:0]  SYM_ZERO  = 8'h01;
  // Bits that must be clear for a symbol to carry a 5-bit payload in [6:2]
  localparam logic [7:0]  DATA_MASK = 8'h83;

  localparam int FRAME_SYMS = 76800;
  localparam int LINE_SYMS  = 80;
  localparam int HSYNC_LEN  = 16;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_DATA  = 2'd1,
    ST_HSYNC = 2'd2
  } lane_state_e;

  typedef enum logic [1:0] {
    SYM_DATA    = 2'd0,
    SYM_MARK    = 2'd1,
    SYM_ILLEGAL = 2'd2
  } sym_class_e;

  typedef struct packed {
    logic        busy;
    logic        frame_start;
    logic        frame_id;
    logic        frame_done;
    logic        line_sync;
    logic        sym_err;
    logic        hsync_err;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [4:0]  wr_y;
    logic [4:0]  wr_c;
  } rx_out_t;

endpackage

// File: rtl/slant_lane_rx_if.sv
// Lane symbol input and sample-pair write port of one slant receive lane.
interface slant_lane_rx_if;

  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [4:0]  wr_y;
  logic [4:0]  wr_c;

  modport master (
    output rx_valid, rx_data,
    input  wr_en, wr_addr, wr_y, wr_c
  );

  modport slave (
    input  rx_valid, rx_data,
    output wr_en, wr_addr, wr_y, wr_c
  );

endinterface

// File: rtl/slant_sym_classify.sv
// Combinational decoder: splits a lane symbol into marker / data / illegal and extracts
// the marker bit and the data payload.
module slant_sym_classify
  import slant_link_pkg::*;
(
  input  logic [7:0] sym,
  output sym_class_e cls,
  output logic       mark_bit,
  output logic [4:0] payload
);

  // Symbol class decode; payload is only meaningful for data symbols
  always_comb begin
    cls      = SYM_ILLEGAL;
    mark_bit = 1'b0;
    payload  = sym[6:2];
    if (sym == SYM_ONE) begin
      cls      = SYM_MARK;
      mark_bit = 1'b1;
    end else if (sym == SYM_ZERO) begin
      cls      = SYM_MARK;
      mark_bit = 1'b0;
    end else if ((sym & DATA_MASK) == 8'h00) begin
      cls = SYM_DATA;
    end else begin
      cls = SYM_ILLEGAL;
    end
  end

endmodule

// File: rtl/slant_lane_rx.sv
// Slant link lane receiver: hunts for the frame header, tracks symbol index and HSYNC
// markers, and turns pairs of data symbols into Y/C sample-pair writes.
module slant_lane_rx
  import slant_link_pkg::*;
(
  input  logic           Cclk,
  input  logic           rst,
  slant_lane_rx_if.slave lane,
  output logic           busy,
  output logic           frame_start,
  output logic           frame_id,
  output logic           frame_done,
  output logic           line_sync,
  output logic           sym_err,
  output logic           hsync_err
);

  sym_class_e  cls_s;
  logic        mark_bit_s;
  logic [4:0]  payload_s;
  logic        is_mark_s;
  logic [23:0] hdr_shift_s;
  logic        hdr_match_s;
  logic [15:0] hs_shift_s;
  logic [4:0]  hs_cnt_inc_s;
  logic        last_sym_s;

  lane_state_e state_r, state_n;
  logic [22:0] hdr_r, hdr_n;
  logic [4:0]  hdr_fill_r, hdr_fill_n;
  logic [16:0] idx_r, idx_n;
  logic [6:0]  lpos_r, lpos_n;
  logic [14:0] hs_sh_r, hs_sh_n;
  logic [4:0]  hs_cnt_r, hs_cnt_n;
  logic [4:0]  y_r, y_n;
  logic        y_ok_r, y_ok_n;
  rx_out_t     out_r, out_n;

  slant_sym_classify u_classify (
    .sym      (lane.rx_data),
    .cls      (cls_s),
    .mark_bit (mark_bit_s),
    .payload  (payload_s)
  );

  assign is_mark_s    = (cls_s == SYM_MARK);
  assign hdr_shift_s  = {hdr_r, mark_bit_s};
  // Only the 23 previous bits are stored; the fill count proves they were all markers
  assign hdr_match_s  = is_mark_s && (hdr_fill_r >= 5'd23) &&
                        ((hdr_shift_s == FRAME1) || (hdr_shift_s == FRAME0));
  assign hs_shift_s   = {hs_sh_r, mark_bit_s};
  assign hs_cnt_inc_s = hs_cnt_r + 5'd1;
  assign last_sym_s   = (idx_r == 17'(FRAME_SYMS - 1));

  // State, counters and registered outputs
  always_ff @(posedge Cclk) begin
    if (rst) begin
      state_r    <= ST_HUNT;
      hdr_r      <= 23'd0;
      hdr_fill_r <= 5'd0;
      idx_r      <= 17'd0;
      lpos_r     <= 7'd0;
      hs_sh_r    <= 15'd0;
      hs_cnt_r   <= 5'd0;
      y_r        <= 5'd0;
      y_ok_r     <= 1'b0;
      out_r      <= '0;
    end else begin
      state_r    <= state_n;
      hdr_r      <= hdr_n;
      hdr_fill_r <= hdr_fill_n;
      idx_r      <= idx_n;
      lpos_r     <= lpos_n;
      hs_sh_r    <= hs_sh_n;
      hs_cnt_r   <= hs_cnt_n;
      y_r        <= y_n;
      y_ok_r     <= y_ok_n;
      out_r      <= out_n;
    end
  end

  // Next-state and next-output logic, evaluated per received symbol
  always_comb begin
    state_n    = state_r;
    hdr_n      = hdr_r;
    hdr_fill_n = hdr_fill_r;
    idx_n      = idx_r;
    lpos_n     = lpos_r;
    hs_sh_n    = hs_sh_r;
    hs_cnt_n   = hs_cnt_r;
    y_n        = y_r;
    y_ok_n     = y_ok_r;
    out_n             = out_r;
    out_n.frame_start = 1'b0;
    out_n.frame_done  = 1'b0;
    out_n.line_sync   = 1'b0;
    out_n.sym_err     = 1'b0;
    out_n.hsync_err   = 1'b0;
    out_n.wr_en       = 1'b0;

    if (lane.rx_valid) begin
      if (is_mark_s) begin
        hdr_n      = hdr_shift_s[22:0];
        hdr_fill_n = (hdr_fill_r == 5'd24) ? 5'd24 : hdr_fill_r + 5'd1;
      end else begin
        hdr_n      = 23'd0;
        hdr_fill_n = 5'd0;
      end

      if (hdr_match_s) begin
        out_n.frame_start = 1'b1;
        out_n.frame_id    = (hdr_shift_s == FRAME1);
        state_n  = ST_DATA;
        idx_n    = 17'd0;
        lpos_n   = 7'd0;
        hs_cnt_n = 5'd0;
        y_ok_n   = 1'b0;
      end else if (state_r == ST_HUNT) begin
        state_n = ST_HUNT;
      end else begin
        idx_n  = idx_r + 17'd1;
        lpos_n = (lpos_r == 7'(LINE_SYMS - 1)) ? 7'd0 : lpos_r + 7'd1;
        if ((state_r == ST_HSYNC) && is_mark_s) begin
          hs_sh_n  = hs_shift_s[14:0];
          hs_cnt_n = hs_cnt_inc_s;
          y_ok_n   = 1'b0;
          if (hs_cnt_inc_s == 5'(HSYNC_LEN)) begin
            state_n         = ST_DATA;
            out_n.line_sync = (hs_shift_s == HSYNC);
            out_n.hsync_err = (hs_shift_s != HSYNC);
          end else begin
            state_n = ST_HSYNC;
          end
        end else begin
          // A symbol that cuts an HSYNC short is flagged, then decoded as in DATA
          out_n.hsync_err = (state_r == ST_HSYNC);
          state_n         = ST_DATA;
          case (cls_s)
            SYM_MARK: begin
              state_n         = ST_HSYNC;
              hs_cnt_n        = 5'd1;
              hs_sh_n         = {14'd0, mark_bit_s};
              y_ok_n          = 1'b0;
              out_n.hsync_err = (lpos_r != 7'(LINE_SYMS - 1));
            end
            SYM_DATA: begin
              if (!idx_r[0]) begin
                y_n    = payload_s;
                y_ok_n = 1'b1;
              end else begin
                y_ok_n        = 1'b0;
                out_n.wr_en   = y_ok_r;
                out_n.wr_addr = y_ok_r ? idx_r[16:1] : out_r.wr_addr;
                out_n.wr_y    = y_ok_r ? y_r : out_r.wr_y;
                out_n.wr_c    = y_ok_r ? payload_s : out_r.wr_c;
              end
            end
            SYM_ILLEGAL: begin
              out_n.sym_err = 1'b1;
              y_ok_n        = 1'b0;
            end
            default: begin
              y_ok_n = 1'b0;
            end
          endcase
        end
        if (last_sym_s) begin
          out_n.frame_done = 1'b1;
          state_n          = ST_HUNT;
        end else begin
          out_n.frame_done = 1'b0;
        end
      end
    end else begin
      state_n = state_r;
    end

    out_n.busy = (state_n != ST_HUNT);
  end

  assign busy         = out_r.busy;
  assign frame_start  = out_r.frame_start;
  assign frame_id     = out_r.frame_id;
  assign frame_done   = out_r.frame_done;
  assign line_sync    = out_r.line_sync;
  assign sym_err      = out_r.sym_err;
  assign hsync_err    = out_r.hsync_err;
  assign lane.wr_en   = out_r.wr_en;
  assign lane.wr_addr = out_r.wr_addr;
  assign lane.wr_y    = out_r.wr_y;
  assign lane.wr_c    = out_r.wr_c;

endmodule

// File: tb/tb_slant_lane_rx.sv
// Scoreboard bench for slant_lane_rx: directed frames push expected pair writes into a
// queue that a negedge monitor drains; pulse tallies are compared per scenario.
module tb_slant_lane_rx;
  import slant_link_pkg::*;

  typedef struct packed {
    logic [15:0] addr;
    logic [4:0]  y;
    logic [4:0]  c;
  } wr_t;

  logic Cclk = 1'b0;
  logic rst  = 1'b1;
  logic busy, frame_start, frame_id, frame_done, line_sync, sym_err, hsync_err;
  slant_lane_rx_if bus ();

  int checks = 0;
  int failures = 0;
  int n_fs = 0, n_fd = 0, n_ls = 0, n_se = 0, n_he = 0;
  int b_fs = 0, b_fd = 0, b_ls = 0, b_se = 0, b_he = 0;
  wr_t exp_q[$];
  logic [7:0] syms[$];
  wr_t mon_e;

  slant_lane_rx dut (
    .Cclk        (Cclk),
    .rst         (rst),
    .lane        (bus),
    .busy        (busy),
    .frame_start (frame_start),
    .frame_id    (frame_id),
    .frame_done  (frame_done),
    .line_sync   (line_sync),
    .sym_err     (sym_err),
    .hsync_err   (hsync_err)
  );

  always #5 Cclk = ~Cclk;

  // Monitor: drain the write scoreboard and tally status pulses
  always @(negedge Cclk) begin
    if (bus.wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected got addr=%0d y=%0d c=%0d want no write",
                 bus.wr_addr, bus.wr_y, bus.wr_c);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.wr_addr, bus.wr_y, bus.wr_c} !== mon_e) begin
          failures++;
          $display("FAIL wr_pair got addr=%0d y=%0d c=%0d want addr=%0d y=%0d c=%0d",
                   bus.wr_addr, bus.wr_y, bus.wr_c, mon_e.addr, mon_e.y, mon_e.c);
        end
      end
    end
    if (frame_start) n_fs++;
    if (frame_done)  n_fd++;
    if (line_sync)   n_ls++;
    if (sym_err)     n_se++;
    if (hsync_err)   n_he++;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge Cclk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (n) begin
      @(posedge Cclk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(1);
  endtask

  task automatic send_header(input logic [23:0] h);
    for (int k = 23; k >= 0; k--) send(h[k] ? SYM_ONE : SYM_ZERO);
  endtask

  function automatic logic [7:0] dsym(input int i);
    logic [31:0] v;
    v = i;
    return {1'b0, v[4:0] ^ v[9:5], 2'b00};
  endfunction

  function automatic logic is_data_sym(input logic [7:0] s);
    return (s[7] == 1'b0) && (s[1:0] == 2'b00);
  endfunction

  task automatic add_hsync(input logic [15:0] p);
    for (int k = 15; k >= 0; k--) syms.push_back(p[k] ? SYM_ONE : SYM_ZERO);
  endtask

  task automatic add_data_to(input int n);
    while (syms.size() < n) syms.push_back(dsym(int'(syms.size())));
  endtask

  // Expected writes: a pair is written only when both of its symbols are data
  task automatic play_frame(input logic [23:0] hdr);
    logic [7:0] a, b;
    wr_t w;
    for (int i = 0; i + 1 < int'(syms.size()); i += 2) begin
      a = syms[i];
      b = syms[i+1];
      if (is_data_sym(a) && is_data_sym(b)) begin
        w.addr = 16'(i / 2);
        w.y    = a[6:2];
        w.c    = b[6:2];
        exp_q.push_back(w);
      end
    end
    send_header(hdr);
    foreach (syms[i]) send(syms[i]);
    syms.delete();
  endtask

  task automatic check_counts(input string tag, input int fs, input int fd, input int ls,
                              input int se, input int he);
    idle(4);
    check({tag, "_frame_start"}, 32'(n_fs - b_fs), 32'(fs));
    check({tag, "_frame_done"},  32'(n_fd - b_fd), 32'(fd));
    check({tag, "_line_sync"},   32'(n_ls - b_ls), 32'(ls));
    check({tag, "_sym_err"},     32'(n_se - b_se), 32'(se));
    check({tag, "_hsync_err"},   32'(n_he - b_he), 32'(he));
    check({tag, "_pending_wr"},  32'(exp_q.size()), 32'd0);
    exp_q.delete();
    b_fs = n_fs; b_fd = n_fd; b_ls = n_ls; b_se = n_se; b_he = n_he;
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst = 1'b1;
    idle(3);
    @(negedge Cclk);
    check("rst_flags", 32'({busy, frame_start, frame_id, frame_done, line_sync, sym_err,
                            hsync_err, bus.wr_en}), 32'd0);
    check("rst_wr_port", 32'({bus.wr_addr, bus.wr_y, bus.wr_c}), 32'd0);
    rst = 1'b0;
    idle(1);

    // FRAME1 header and two hand-decoded pairs
    exp_q.push_back(wr_t'{16'd0, 5'd31, 5'd1});
    exp_q.push_back(wr_t'{16'd1, 5'd16, 5'd0});
    send_header(FRAME1);
    @(negedge Cclk);
    check("s1_frame_start_latency", 32'(frame_start), 32'd1);
    check("s1_frame_id", 32'(frame_id), 32'd1);
    check("s1_busy", 32'(busy), 32'd1);
    send(8'h7c); send(8'h04); send(8'h40); send(8'h00);
    check_counts("s1", 1, 0, 0, 0, 0);
    do_reset();

    // Full FRAME0 frame; the last HSYNC starts on the final frame symbol
    while (syms.size() < FRAME_SYMS) begin
      if ((syms.size() % LINE_SYMS) == (LINE_SYMS - 1)) add_hsync(HSYNC);
      else syms.push_back(dsym(int'(syms.size())));
    end
    play_frame(FRAME0);
    check_counts("s2", 1, 1, 959, 0, 0);
    check("s2_frame_id", 32'(frame_id), 32'd0);
    check("s2_busy", 32'(busy), 32'd0);
    do_reset();

    // Misplaced HSYNC at index 50, then a correctly placed HSYNC with a bad pattern
    add_data_to(50);
    add_hsync(HSYNC);
    add_data_to(79);
    add_hsync(16'ha354);
    add_data_to(100);
    play_frame(FRAME1);
    check_counts("s3", 1, 0, 1, 0, 2);
    check("s3_busy", 32'(busy), 32'd1);
    do_reset();

    // Illegal symbol at index 10 drops pair 5 only
    add_data_to(10);
    syms.push_back(8'h81);
    add_data_to(20);
    play_frame(FRAME1);
    check_counts("s4", 1, 0, 0, 1, 0);
    do_reset();

    // FRAME0 header injected at index 1000 resyncs the lane
    add_data_to(1000);
    play_frame(FRAME1);
    add_data_to(4);
    play_frame(FRAME0);
    check_counts("s5", 2, 0, 0, 0, 3);
    check("s5_frame_id", 32'(frame_id), 32'd0);
    do_reset();

    // Reset at index 500 drops the frame; idle symbols afterwards are ignored
    add_data_to(500);
    play_frame(FRAME1);
    rst = 1'b1;
    send(8'h00);
    rst = 1'b0;
    repeat (200) send(8'h00);
    check_counts("s6", 1, 0, 0, 0, 0);
    check("s6_busy", 32'(busy), 32'd0);
    check("s6_frame_id", 32'(frame_id), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
